// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (640x480@60Hz from 100 MHz)
//
// Purpose: divides clk down to the pixel rate and walks a raster of
// H_TOTAL x V_TOTAL pixel periods. Sync and active-video decodes are
// registered from the next-state counters, so they change on the same
// edge as hCount/vCount.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   pix_en     out  one-clk strobe per pixel period; counters advance on it
//   hCount     out  horizontal position, 0..H_TOTAL-1
//   vCount     out  vertical position, 0..V_TOTAL-1
//   hSync      out  horizontal sync, active low
//   vSync      out  vertical sync, active low
//   bright     out  high inside the visible window
//   frame_tick out  one-clk strobe when the raster wraps to (0,0)
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 783,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
);

  // CLK_DIV=1 still needs a 1-bit divider register that stays at 0.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SW     = 10'(H_SYNC);
  localparam logic [9:0]       V_SW     = 10'(V_SYNC);
  localparam logic [9:0]       H_DS     = 10'(H_DISP_START);
  localparam logic [9:0]       H_DE     = 10'(H_DISP_END);
  localparam logic [9:0]       V_DS     = 10'(V_DISP_START);
  localparam logic [9:0]       V_DE     = 10'(V_DISP_END);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hs;
  logic             r_vs;
  logic             r_br;
  logic             r_ft;

  logic [DIV_W-1:0] w_div_next;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_hs;
  logic             w_vs;
  logic             w_br;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_h_wrap   = (r_h == H_LAST);
    w_v_wrap   = (r_v == V_LAST);
    w_h_next   = r_h;
    w_v_next   = r_v;
    if (r_pix_en) begin
      if (w_h_wrap) begin
        w_h_next = '0;
        w_v_next = w_v_wrap ? '0 : r_v + 10'd1;
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
    // Decoding next-state values keeps the decodes aligned with the counters.
    w_hs = ~(w_h_next < H_SW);
    w_vs = ~(w_v_next < V_SW);
    w_br = (w_h_next >= H_DS) && (w_h_next <= H_DE) &&
           (w_v_next >= V_DS) && (w_v_next <= V_DE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
      r_h      <= '0;
      r_v      <= '0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_br     <= 1'b0;
      r_ft     <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      // pix_en is high during the clk in which r_div sits at its last value.
      r_pix_en <= (w_div_next == DIV_LAST);
      r_h      <= w_h_next;
      r_v      <= w_v_next;
      r_ft     <= r_pix_en & w_h_wrap & w_v_wrap;
      if (r_pix_en) begin
        r_hs <= w_hs;
        r_vs <= w_vs;
        r_br <= w_br;
      end
    end
  end

  assign pix_en     = r_pix_en;
  assign hCount     = r_h;
  assign vCount     = r_v;
  assign hSync      = r_hs;
  assign vSync      = r_vs;
  assign bright     = r_br;
  assign frame_tick = r_ft;

endmodule
